// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encodings
// and default timing constants for a 50 MHz clock.
package key_conditioner_pkg;

    localparam int KC_STATE_W = 3;

    typedef enum logic [KC_STATE_W-1:0] {
        KC_IDLE    = 3'd0,
        KC_DEB_DN  = 3'd1,
        KC_PRESSED = 3'd2,
        KC_HELD    = 3'd3,
        KC_DEB_UP  = 3'd4
    } kc_state_e;

    // 20 ms debounce, 0.5 s hold, 0.1 s repeat at 50 MHz.
    localparam int KC_DEBOUNCE_CYCLES = 1000000;
    localparam int KC_HOLD_CYCLES     = 25000000;
    localparam int KC_REPEAT_CYCLES   = 5000000;
    localparam int KC_CNT_W           = 25;

endpackage

// File: rtl/key_debounce_fsm.sv
// One key: 2-flop synchronizer, debounce/hold/repeat FSM with registered
// level, hold and one-cycle press/release pulses. State is exported for debug.
module key_debounce_fsm
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = KC_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = KC_REPEAT_CYCLES,
    parameter int CNT_W           = KC_CNT_W
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  key_n,
    input  logic                  repeat_en,
    output logic                  key_level,
    output logic                  key_press,
    output logic                  key_release,
    output logic                  key_hold,
    output logic [KC_STATE_W-1:0] state
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             sync_q;
    logic             p;
    kc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             hold_q, hold_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Synchronizer resets to "not pressed" so a key held through reset
    // must be re-debounced.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b0;
            p      <= 1'b0;
        end else begin
            sync_q <= ~key_n;
            p      <= sync_q;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= KC_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            hold_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // A change of p always wins over a threshold hit in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        level_d   = level_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            KC_IDLE: begin
                cnt_d = '0;
                if (p) state_d = KC_DEB_DN;
            end
            KC_DEB_DN: begin
                if (!p) begin
                    state_d = KC_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = KC_PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            KC_PRESSED: begin
                if (!p) begin
                    state_d = KC_DEB_UP;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = KC_HELD;
                    hold_d  = 1'b1;
                    press_d = repeat_en;
                    cnt_d   = '0;
                end
            end
            KC_HELD: begin
                if (!p) begin
                    state_d = KC_DEB_UP;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    press_d = repeat_en;
                    cnt_d   = '0;
                end
            end
            KC_DEB_UP: begin
                if (p) begin
                    state_d = hold_q ? KC_HELD : KC_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = KC_IDLE;
                    level_d   = 1'b0;
                    hold_d    = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = KC_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_level   = level_q;
    assign key_hold    = hold_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign state       = state_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions NUM_KEYS raw active-low buttons into debounced level, press,
// release and hold signals; one independent key_debounce_fsm per key.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = KC_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = KC_REPEAT_CYCLES,
    parameter int CNT_W           = KC_CNT_W
) (
    input  logic                           CLOCK_50,
    input  logic                           reset_n,
    input  logic [NUM_KEYS-1:0]            key_n,
    input  logic [NUM_KEYS-1:0]            repeat_en,
    output logic [NUM_KEYS-1:0]            key_level,
    output logic [NUM_KEYS-1:0]            key_press,
    output logic [NUM_KEYS-1:0]            key_release,
    output logic [NUM_KEYS-1:0]            key_hold,
    output logic [NUM_KEYS*KC_STATE_W-1:0] key_state
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .CNT_W          (CNT_W)
        ) u_key (
            .CLOCK_50   (CLOCK_50),
            .reset_n    (reset_n),
            .key_n      (key_n[i]),
            .repeat_en  (repeat_en[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_hold   (key_hold[i]),
            .state      (key_state[i*KC_STATE_W +: KC_STATE_W])
        );
    end

endmodule
